// File: rtl/rr_decode_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : rr_decode_scheduler
// Brief    : Round-robin owner of a shared 4-to-16 one-hot select; holds each
//            grant until release, request/mask drop, or hold timeout.
// Revision : 1.0 - initial release
// ============================================================================
module rr_decode_scheduler #(
    parameter int MAX_HOLD = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] req,
    input  logic [15:0] mask,
    input  logic        done,
    output logic        grant_valid,
    output logic [3:0]  grant_idx,
    output logic [15:0] grant_oh,
    output logic        timeout_pulse
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    localparam logic [7:0] C_MAX_HOLD = 8'(MAX_HOLD);
    localparam logic [7:0] C_CNT_SAT  = 8'd255;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_ptr,      w_ptr_nxt;
    logic [7:0]  r_hold_cnt, w_hold_cnt_nxt;
    logic [3:0]  r_idx,      w_idx_nxt;
    logic        r_valid,    w_valid_nxt;
    logic [15:0] r_oh,       w_oh_nxt;
    logic        r_tp,       w_tp_nxt;

    logic [15:0] w_elig;
    logic        w_found;
    logic [3:0]  w_winner;
    logic        w_rel_other;
    logic        w_to;

    assign w_elig = req & mask;

    // Search starts one past the last owner, so the previous owner is tried last.
    always_comb begin
        w_found  = 1'b0;
        w_winner = 4'd0;
        for (int i = 0; i < 16; i++) begin
            logic [3:0] cand;
            cand = r_ptr + 4'(i + 1);
            if (!w_found && w_elig[cand]) begin
                w_found  = 1'b1;
                w_winner = cand;
            end
        end
    end

    assign w_rel_other = done | ~req[r_idx] | ~mask[r_idx];
    assign w_to        = (MAX_HOLD != 0) && (r_hold_cnt == C_MAX_HOLD);

    always_comb begin
        w_state_nxt    = r_state;
        w_ptr_nxt      = r_ptr;
        w_hold_cnt_nxt = r_hold_cnt;
        w_idx_nxt      = r_idx;
        w_valid_nxt    = r_valid;
        w_oh_nxt       = r_oh;
        w_tp_nxt       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt    = S_BUSY;
                    w_idx_nxt      = w_winner;
                    w_oh_nxt       = 16'd1 << w_winner;
                    w_valid_nxt    = 1'b1;
                    w_hold_cnt_nxt = 8'd1;
                end
            end
            S_BUSY: begin
                if (w_rel_other || w_to) begin
                    w_state_nxt    = S_IDLE;
                    w_valid_nxt    = 1'b0;
                    w_oh_nxt       = 16'd0;
                    w_ptr_nxt      = r_idx;
                    w_hold_cnt_nxt = 8'd0;
                    // Timeout is flagged only when nothing else caused the release.
                    w_tp_nxt       = w_to && !w_rel_other;
                end else if (r_hold_cnt != C_CNT_SAT) begin
                    w_hold_cnt_nxt = r_hold_cnt + 8'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_valid_nxt = 1'b0;
                w_oh_nxt    = 16'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_ptr      <= 4'd15;
            r_hold_cnt <= 8'd0;
            r_idx      <= 4'd0;
            r_valid    <= 1'b0;
            r_oh       <= 16'd0;
            r_tp       <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ptr      <= w_ptr_nxt;
            r_hold_cnt <= w_hold_cnt_nxt;
            r_idx      <= w_idx_nxt;
            r_valid    <= w_valid_nxt;
            r_oh       <= w_oh_nxt;
            r_tp       <= w_tp_nxt;
        end
    end

    assign grant_valid   = r_valid;
    assign grant_idx     = r_idx;
    assign grant_oh      = r_oh;
    assign timeout_pulse = r_tp;

endmodule
`default_nettype wire

// File: tb/tb_rr_decode_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_decode_scheduler
// Brief    : Scoreboard bench for rr_decode_scheduler (MAX_HOLD = 8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_decode_scheduler;

    localparam int MAX_HOLD = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] req;
    logic [15:0] mask;
    logic        done;
    logic        grant_valid;
    logic [3:0]  grant_idx;
    logic [15:0] grant_oh;
    logic        timeout_pulse;

    rr_decode_scheduler #(.MAX_HOLD(MAX_HOLD)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .mask         (mask),
        .done         (done),
        .grant_valid  (grant_valid),
        .grant_idx    (grant_idx),
        .grant_oh     (grant_oh),
        .timeout_pulse(timeout_pulse)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        v;
        logic [3:0]  idx;
        logic [15:0] oh;
        logic        tp;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model state
    logic       m_busy;
    logic [3:0] m_ptr;
    logic [3:0] m_idx;
    int         m_cnt;
    logic       m_tp;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_busy = 1'b0;
        m_ptr  = 4'd15;
        m_idx  = 4'd0;
        m_cnt  = 0;
        m_tp   = 1'b0;
    endfunction

    function automatic void model_edge();
        logic [15:0] elig;
        logic        other;
        logic        to;
        elig = req & mask;
        m_tp = 1'b0;
        if (!m_busy) begin
            for (int k = 1; k <= 16; k++) begin
                if (!m_busy && elig[(int'(m_ptr) + k) % 16]) begin
                    m_busy = 1'b1;
                    m_idx  = 4'((int'(m_ptr) + k) % 16);
                    m_cnt  = 1;
                end
            end
        end else begin
            other = done || !req[m_idx] || !mask[m_idx];
            to    = (MAX_HOLD != 0) && (m_cnt == MAX_HOLD);
            if (other || to) begin
                m_busy = 1'b0;
                m_ptr  = m_idx;
                m_cnt  = 0;
                m_tp   = to && !other;
            end else if (m_cnt < 255) begin
                m_cnt = m_cnt + 1;
            end
        end
    endfunction

    // Predict, clock, then compare against the oldest prediction.
    task automatic step();
        exp_t e;
        model_edge();
        e.v   = m_busy;
        e.idx = m_idx;
        e.oh  = m_busy ? (16'd1 << m_idx) : 16'd0;
        e.tp  = m_tp;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("valid", 32'(grant_valid), 32'(e.v));
        chk("idx",   32'(grant_idx),   32'(e.idx));
        chk("oh",    32'(grant_oh),    32'(e.oh));
        chk("tp",    32'(timeout_pulse), 32'(e.tp));
    endtask

    task automatic wait_grant(input string tag);
        int n;
        n = 0;
        while (!grant_valid && n < 4) begin
            step();
            n++;
        end
        if (!grant_valid) chk(tag, 32'(grant_valid), 32'd1);
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        req   = 16'hFFFF;
        mask  = 16'hFFFF;
        done  = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(grant_valid), 32'd0);
        chk("rst_oh",    32'(grant_oh),    32'd0);
        chk("rst_tp",    32'(timeout_pulse), 32'd0);
        chk("rst_idx",   32'(grant_idx),   32'd0);
        rst_n = 1'b1;

        // Rotation with done on each grant's first cycle
        for (int j = 0; j <= 16; j++) begin
            wait_grant("rot_wait");
            chk("rot_idx", 32'(grant_idx), 32'(j % 16));
            if (j == 0) chk("first_oh", 32'(grant_oh), 32'h0001);
            done = 1'b1;
            step();
            done = 1'b0;
            chk("rot_gap", 32'(grant_valid), 32'd0);
        end
        req = 16'h0000;
        step();

        // Single requester with done release and re-grant
        req = 16'h0020;
        step();
        chk("single_idx", 32'(grant_idx), 32'd5);
        chk("single_oh",  32'(grant_oh),  32'h0020);
        done = 1'b1;
        step();
        done = 1'b0;
        chk("single_gap", 32'(grant_valid), 32'd0);
        step();
        chk("single_regrant", 32'(grant_idx), 32'd5);
        req = 16'h0000;
        step();
        step();

        // Timeout: held request, no done
        req = 16'h0008;
        wait_grant("to_wait");
        n = 0;
        while (grant_valid && n < 20) begin
            step();
            n++;
        end
        chk("to_len", 32'(n), 32'(MAX_HOLD));
        chk("to_pulse", 32'(timeout_pulse), 32'd1);
        step();
        chk("to_regrant", 32'(grant_idx), 32'd3);
        repeat (MAX_HOLD - 1) step();
        done = 1'b1;
        step();
        done = 1'b0;
        chk("to_done_nopulse", 32'(timeout_pulse), 32'd0);
        req = 16'h0000;
        step();

        // Mask drop mid-hold, then wrap past 7 to 0
        req = 16'h0081;
        wait_grant("mask_wait");
        chk("mask_idx", 32'(grant_idx), 32'd7);
        step();
        mask = 16'hFF7F;
        step();
        chk("mask_rel", 32'(grant_valid), 32'd0);
        chk("mask_nopulse", 32'(timeout_pulse), 32'd0);
        mask = 16'hFFFF;
        step();
        chk("mask_wrap", 32'(grant_idx), 32'd0);

        // Reset while idx 9 is granted
        req = 16'h0200;
        n = 0;
        while (!(grant_valid && grant_idx == 4'd9) && n < 6) begin
            step();
            n++;
        end
        chk("rst9_idx", 32'(grant_idx), 32'd9);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rstmid_valid", 32'(grant_valid), 32'd0);
        chk("rstmid_oh",    32'(grant_oh),    32'd0);
        chk("rstmid_idx",   32'(grant_idx),   32'd0);
        req = 16'h0201;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        chk("rstmid_first", 32'(grant_idx), 32'd0);

        // Random traffic against the model
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 3) == 0) req = 16'($urandom);
            if ($urandom_range(0, 5) == 0) mask = 16'($urandom) | 16'hF0F0;
            done = ($urandom_range(0, 6) == 0);
            step();
        end
        done = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
